// File: rtl/store_buffer_pkg.sv
// Shared LC-3b types, extended with the store buffer entry layout
// and the two store buffer FSM state encodings.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   localparam int SB_DEPTH = 4;

   typedef struct packed {
      lc3b_word      addr;
      lc3b_word      data;
      lc3b_mem_wmask wmask;
   } sb_entry_t;

   typedef enum logic [1:0] {
      U_IDLE,
      U_RESP,
      U_LOAD
   } sb_up_state_t;

   typedef enum logic {
      D_IDLE,
      D_WRITE
   } sb_dr_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with head/tail/count and a word-address
// match across all occupied entries.
module sb_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = SB_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enq,
   input  sb_entry_t     enq_entry,
   input  logic          deq,
   input  logic [14:0]   query_key,
   output sb_entry_t     head_entry,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          match
);

   sb_entry_t        mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (enq) begin
            mem[tail] <= enq_entry;
            tail      <= tail + 1'b1;
         end
         if (deq)
            head <= head + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (deq && !enq)
            count <= count - 1'b1;
      end
   end

   // An entry is live when its distance from head is below count.
   always_comb begin
      valid = '0;
      hit   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = {1'b0, PW'(i) - head} < count;
         hit[i]   = mem[i].addr[15:1] == query_key;
      end
   end

   assign match      = |(valid & hit);
   assign head_entry = mem[head];
   assign full       = count == CW'(DEPTH);
   assign empty      = count == '0;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the mem stage and the L1 dcache:
// stores are acked at once and drained in order, loads pass through.
module store_buffer
   import lc3b_types::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [ADDR_W-1:0]      cpu_address,
   input  logic [DATA_W-1:0]      cpu_wdata,
   input  logic                   cpu_read,
   input  logic                   cpu_write,
   input  logic [1:0]             cpu_byte_enable,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   cpu_resp,
   output logic [ADDR_W-1:0]      dc_address,
   output logic [DATA_W-1:0]      dc_wdata,
   output logic [1:0]             dc_byte_enable,
   output logic                   dc_read,
   output logic                   dc_write,
   input  logic [DATA_W-1:0]      dc_rdata,
   input  logic                   dc_resp,
   input  logic                   sb_flush,
   output logic [$clog2(DEPTH):0] sb_count,
   output logic                   sb_empty
);

   sb_up_state_t u_state;
   sb_up_state_t u_next;
   sb_dr_state_t d_state;
   sb_dr_state_t d_next;

   sb_entry_t enq_entry;
   sb_entry_t head_entry;
   logic      enq;
   logic      deq;
   logic      full;
   logic      empty;
   logic      match;
   logic      ld_go;

   assign enq_entry = '{
      addr:  lc3b_word'(cpu_address),
      data:  lc3b_word'(cpu_wdata),
      wmask: cpu_byte_enable
   };

   // A slot frees up in the same cycle a drain completes.
   assign deq = (d_state == D_WRITE) && dc_resp;
   assign enq = (u_state == U_IDLE) && cpu_write && !sb_flush
             && (!full || deq);
   assign ld_go = cpu_read && !cpu_write && !sb_flush && !match;

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .enq        (enq),
      .enq_entry  (enq_entry),
      .deq        (deq),
      .query_key  (cpu_address[15:1]),
      .head_entry (head_entry),
      .count      (sb_count),
      .full       (full),
      .empty      (empty),
      .match      (match)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         u_state   <= U_IDLE;
         d_state   <= D_IDLE;
         cpu_rdata <= '0;
      end else begin
         u_state <= u_next;
         d_state <= d_next;
         if (dc_read && dc_resp)
            cpu_rdata <= dc_rdata;
      end
   end

   always_comb begin
      u_next = u_state;
      unique case (u_state)
         U_IDLE: begin
            if (enq)
               u_next = U_RESP;
            else if (ld_go)
               u_next = U_LOAD;
         end
         U_RESP: u_next = U_IDLE;
         U_LOAD: begin
            if (dc_read && dc_resp)
               u_next = U_RESP;
         end
         default: u_next = U_IDLE;
      endcase
   end

   // A waiting load claims the port only between drain writes.
   always_comb begin
      d_next = d_state;
      unique case (d_state)
         D_IDLE: begin
            if (!empty && u_state != U_LOAD)
               d_next = D_WRITE;
         end
         D_WRITE: begin
            if (dc_resp)
               d_next = D_IDLE;
         end
         default: d_next = D_IDLE;
      endcase
   end

   assign dc_read  = (u_state == U_LOAD) && (d_state == D_IDLE);
   assign dc_write = d_state == D_WRITE;
   assign cpu_resp = u_state == U_RESP;
   assign sb_empty = empty;

   assign dc_address     = dc_read ? cpu_address
                                   : ADDR_W'(head_entry.addr);
   assign dc_wdata       = DATA_W'(head_entry.data);
   assign dc_byte_enable = dc_read ? 2'b00 : head_entry.wmask;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a dcache model with variable latency and a
// program-order memory/pending-store model that judge every transaction.
module tb_store_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
   logic [15:0] dc_address, dc_wdata, dc_rdata;
   logic        cpu_read, cpu_write, cpu_resp;
   logic        dc_read, dc_write, dc_resp;
   logic        sb_flush, sb_empty;
   logic [1:0]  cpu_byte_enable, dc_byte_enable;
   logic [2:0]  sb_count;

   store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_address     (cpu_address),
      .cpu_wdata       (cpu_wdata),
      .cpu_read        (cpu_read),
      .cpu_write       (cpu_write),
      .cpu_byte_enable (cpu_byte_enable),
      .cpu_rdata       (cpu_rdata),
      .cpu_resp        (cpu_resp),
      .dc_address      (dc_address),
      .dc_wdata        (dc_wdata),
      .dc_byte_enable  (dc_byte_enable),
      .dc_read         (dc_read),
      .dc_write        (dc_write),
      .dc_rdata        (dc_rdata),
      .dc_resp         (dc_resp),
      .sb_flush        (sb_flush),
      .sb_count        (sb_count),
      .sb_empty        (sb_empty)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic [1:0]  m;
   } st_t;

   st_t         refq[$];
   logic [15:0] refmem [32768];
   logic [15:0] dcmem  [32768];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int rd_resp_cyc = 0;
   int rd_pend = 0;
   int lat_fix = 0;
   bit hold = 1'b0;

   logic        cur_wr;
   logic [15:0] cur_a, cur_d;
   logic [1:0]  cur_m;

   bit          busy;
   int          cnt;
   logic [33:0] lt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old,
                                         input logic [15:0] d,
                                         input logic [1:0] m);
      logic [15:0] r;
      r = old;
      if (m[0]) r[7:0] = d[7:0];
      if (m[1]) r[15:8] = d[15:8];
      return r;
   endfunction

   // dcache model: responds latency cycles after a request first appears
   initial begin
      dc_resp  = 1'b0;
      dc_rdata = '0;
      busy     = 1'b0;
      cnt      = 0;
      forever begin
         @(negedge clk);
         dc_resp = 1'b0;
         if (!reset_n) begin
            busy = 1'b0;
            continue;
         end
         if (!busy && (dc_write || dc_read)) begin
            busy = 1'b1;
            cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
            lt   = {dc_address, dc_wdata, dc_byte_enable};
            if (dc_read) begin
               bit haz;
               haz = 1'b0;
               foreach (refq[i])
                  if (refq[i].a[15:1] == dc_address[15:1]) haz = 1'b1;
               chk("rd_hazard", haz, 0);
               chk("rd_addr", dc_address, cur_a);
               rd_pend = refq.size();
            end
         end
         if (busy && !hold) begin
            if (cnt == 0) begin
               busy    = 1'b0;
               dc_resp = 1'b1;
               if (dc_write) begin
                  chk("wr_stable", {dc_address, dc_wdata, dc_byte_enable}, lt);
                  chk("wr_pending", refq.size() > 0, 1);
                  if (refq.size() > 0) begin
                     st_t e;
                     e = refq.pop_front();
                     chk("wr_addr", dc_address, e.a);
                     chk("wr_data", dc_wdata, e.d);
                     chk("wr_mask", dc_byte_enable, e.m);
                  end
                  dcmem[dc_address[15:1]] = merge(dcmem[dc_address[15:1]],
                                                  dc_wdata, dc_byte_enable);
               end else begin
                  dc_rdata    = dcmem[dc_address[15:1]];
                  rd_resp_cyc = cyc;
               end
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic start_req(input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] m);
      @(posedge clk);
      #1;
      cur_wr          = wr;
      cur_a           = a;
      cur_d           = d;
      cur_m           = m;
      cpu_read        = rd;
      cpu_write       = wr;
      cpu_address     = a;
      cpu_wdata       = d;
      cpu_byte_enable = m;
   endtask

   task automatic wait_resp(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (cpu_resp) got = 1'b1;
      end
      if (got) begin
         if (cur_wr) begin
            refq.push_back('{a: cur_a, d: cur_d, m: cur_m});
            refmem[cur_a[15:1]] = merge(refmem[cur_a[15:1]], cur_d, cur_m);
         end else begin
            chk("ld_data", cpu_rdata, refmem[cur_a[15:1]]);
            chk("ld_lat", cyc - rd_resp_cyc, 1);
         end
         @(posedge clk);
         #1;
         cpu_read  = 1'b0;
         cpu_write = 1'b0;
         @(negedge clk);
         chk("resp_pulse", cpu_resp, 0);
      end
   endtask

   task automatic do_op(input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] m);
      bit got;
      start_req(rd, wr, a, d, m);
      wait_resp(60, got);
      chk(tag, got, 1);
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 200 && !sb_empty; i++)
         @(negedge clk);
      @(negedge clk);
      chk(tag, sb_count, 0);
      chk({tag, "_q"}, refq.size(), 0);
   endtask

   initial begin
      bit got;
      reset_n         = 1'b0;
      cpu_read        = 1'b0;
      cpu_write       = 1'b0;
      cpu_address     = '0;
      cpu_wdata       = '0;
      cpu_byte_enable = '0;
      sb_flush        = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         refmem[i] = '0;
         dcmem[i]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_resp", cpu_resp, 0);
      chk("rst_rd", dc_read, 0);
      chk("rst_wr", dc_write, 0);
      chk("rst_be", dc_byte_enable, 0);
      chk("rst_cnt", sb_count, 0);
      chk("rst_empty", sb_empty, 1);
      chk("rst_rdata", cpu_rdata, 0);
      reset_n = 1'b1;

      // single store, dcache latency 2
      lat_fix = 2;
      do_op("t1_resp", 0, 1, 16'h1000, 16'hBEEF, 2'b11);
      chk("t1_cnt1", sb_count, 1);
      wait_empty("t1_drain");

      // fill to capacity with the dcache stalled
      lat_fix = 1;
      hold    = 1'b1;
      for (int i = 0; i < 4; i++)
         do_op("t2_resp", 0, 1, 16'(16'h10 + 2 * i), 16'(16'hA0 + i), 2'b11);
      chk("t2_cnt4", sb_count, 4);
      start_req(0, 1, 16'h18, 16'hA4, 2'b11);
      wait_resp(8, got);
      chk("t2_stall", got, 0);
      chk("t2_full", sb_count, 4);
      hold = 1'b0;
      wait_resp(20, got);
      chk("t2_accept", got, 1);
      wait_empty("t2_drain");

      // load bypasses a non-matching pending store
      hold = 1'b1;
      do_op("t3_st0", 0, 1, 16'h2100, 16'h5555, 2'b11);
      do_op("t3_st1", 0, 1, 16'h2000, 16'h6666, 2'b11);
      dcmem[16'h3000 >> 1]  = 16'h1234;
      refmem[16'h3000 >> 1] = 16'h1234;
      start_req(1, 0, 16'h3000, 16'h0, 2'b00);
      repeat (3) @(negedge clk);
      hold = 1'b0;
      wait_resp(40, got);
      chk("t3_resp", got, 1);
      chk("t3_rdata", cpu_rdata, 16'h1234);
      chk("t3_bypass", rd_pend, 1);
      wait_empty("t3_drain");

      // load to the same word waits for the matching store to drain
      hold = 1'b1;
      do_op("t4_st0", 0, 1, 16'h2100, 16'h7777, 2'b11);
      do_op("t4_st1", 0, 1, 16'h2000, 16'h8888, 2'b11);
      start_req(1, 0, 16'h2001, 16'h0, 2'b00);
      repeat (3) @(negedge clk);
      hold = 1'b0;
      wait_resp(40, got);
      chk("t4_resp", got, 1);
      chk("t4_after", rd_pend, 0);
      chk("t4_rdata", cpu_rdata, 16'h8888);
      wait_empty("t4_drain");

      // byte store passes data and mask unmodified
      lat_fix = 0;
      do_op("t5_st", 0, 1, 16'h4001, 16'hAB00, 2'b10);
      wait_empty("t5_drain");
      chk("t5_mem", dcmem[16'h4000 >> 1], 16'hAB00);

      // flush blocks acceptance while draining continues
      hold = 1'b1;
      do_op("fl_st0", 0, 1, 16'h0040, 16'h1111, 2'b11);
      do_op("fl_st1", 0, 1, 16'h0042, 16'h2222, 2'b01);
      sb_flush = 1'b1;
      start_req(0, 1, 16'h0044, 16'h3333, 2'b11);
      hold = 1'b0;
      wait_resp(30, got);
      chk("fl_block", got, 0);
      chk("fl_empty", sb_empty, 1);
      sb_flush = 1'b0;
      wait_resp(10, got);
      chk("fl_accept", got, 1);
      wait_empty("fl_drain");

      // randomized mix of stores, loads and read+write collisions
      for (int n = 0; n < 150; n++) begin
         int op;
         op = int'($urandom_range(0, 3));
         do_op("rnd_resp", op == 1 || op == 3, op != 1,
               16'($urandom_range(0, 31)), 16'($urandom),
               2'($urandom_range(1, 3)));
      end
      wait_empty("rnd_drain");

      // asynchronous reset in the middle of a drain
      lat_fix = 1;
      hold    = 1'b1;
      for (int i = 0; i < 3; i++)
         do_op("t6_st", 0, 1, 16'(16'h0080 + 2 * i), 16'(16'hC0 + i), 2'b11);
      chk("t6_pre_wr", dc_write, 1);
      chk("t6_pre_cnt", sb_count, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_wr", dc_write, 0);
      chk("t6_cnt", sb_count, 0);
      chk("t6_empty", sb_empty, 1);
      chk("t6_be", dc_byte_enable, 0);
      repeat (2) @(negedge clk);
      refq.delete();
      for (int i = 0; i < 32768; i++)
         refmem[i] = dcmem[i];
      hold    = 1'b0;
      reset_n = 1'b1;
      do_op("t6_post", 0, 1, 16'h0090, 16'hD00D, 2'b11);
      wait_empty("t6_drain");
      do_op("t6_ld", 1, 0, 16'h0090, 16'h0, 2'b00);
      chk("t6_rdata", cpu_rdata, 16'hD00D);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
